// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM encodings and ID helper for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;

  localparam int unsigned ADDR_BITS = 24;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_ID     = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CMD    = ST_CMD,
    ADDR   = ST_ADDR,
    DATA   = ST_DATA,
    ID     = ST_ID,
    IGNORE = ST_IGNORE
  } state_t;

  // Byte idx of the JEDEC ID stream, MSB byte first, zero once exhausted.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      2'd0:    b = id[23:16];
      2'd1:    b = id[15:8];
      2'd2:    b = id[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// N-stage synchronizer for an asynchronous input with single-cycle edge pulses.
module spi_in_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [N-1:0] chain;
  logic         prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[N-2:0], din};
      prev  <= chain[N-1];
    end
  end

  assign rise = chain[N-1] & ~prev;
  assign fall = ~chain[N-1] & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash emulator: READ (0x03) from a memory port, JEDEC ID (0x9F).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              active,
  output logic              cmd_err
);

  logic sclk_rise_raw;
  logic sclk_fall_raw;

  spi_in_sync #(.N(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise_raw),
    .fall (sclk_fall_raw)
  );

  logic [SYNC_STAGES-1:0] cs_chain;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   cs_prev;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   cs_rise;
  logic                   cs_fall;

  // cs chain resets low so a cs held low across reset never looks like a fresh fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_chain   <= '0;
      mosi_chain <= '0;
      cs_prev    <= 1'b0;
    end else begin
      cs_chain   <= {cs_chain[SYNC_STAGES-2:0], cs};
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
      cs_prev    <= cs_chain[SYNC_STAGES-1];
    end
  end

  assign cs_s    = cs_chain[SYNC_STAGES-1];
  assign mosi_s  = mosi_chain[SYNC_STAGES-1];
  assign cs_rise = cs_s & ~cs_prev;
  assign cs_fall = ~cs_s & cs_prev;

  logic sck_rise;
  logic sck_fall;
  assign sck_rise = sclk_rise_raw & ~cs_s;
  assign sck_fall = sclk_fall_raw & ~cs_s;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [6:0]  rx;
  logic [23:0] addr;
  logic [7:0]  tx;
  logic [1:0]  id_idx;
  logic        rd_en_d;

  logic [23:0] addr_shift;
  logic [23:0] addr_inc;
  assign addr_shift = {addr[22:0], mosi_s};
  assign addr_inc   = addr + 24'd1;

  assign miso_oe = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx      <= '0;
      addr    <= '0;
      tx      <= '0;
      id_idx  <= '0;
      rd_en_d <= 1'b0;
      miso    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      active  <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      rd_en   <= 1'b0;
      cmd_err <= 1'b0;
      rd_en_d <= rd_en;
      // Memory data is valid the clk after the strobe; capture it on that cycle.
      if (rd_en_d) tx <= rd_data;

      if (cs_rise) begin
        state   <= IDLE;
        active  <= 1'b0;
        miso    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            if (cs_fall) begin
              state   <= CMD;
              active  <= 1'b1;
              rx      <= {6'd0, mosi_s};
              bit_cnt <= sck_rise ? 5'd1 : 5'd0;
            end
          end

          CMD: begin
            if (sck_rise) begin
              rx <= {rx[5:0], mosi_s};
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                case ({rx, mosi_s})
                  CMD_READ: state <= ADDR;
                  CMD_JEDEC: begin
                    state  <= ID;
                    tx     <= id_byte(JEDEC_ID, 2'd0);
                    id_idx <= 2'd1;
                  end
                  default: begin
                    cmd_err <= 1'b1;
                    state   <= IGNORE;
                  end
                endcase
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ADDR: begin
            if (sck_rise) begin
              addr <= addr_shift;
              if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                bit_cnt <= '0;
                rd_en   <= 1'b1;
                rd_addr <= addr_shift[ADDR_W-1:0];
                state   <= DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          DATA: begin
            if (sck_fall) begin
              miso <= tx[7];
              tx   <= {tx[6:0], 1'b0};
            end
            if (sck_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                addr    <= addr_inc;
                rd_en   <= 1'b1;
                rd_addr <= addr_inc[ADDR_W-1:0];
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ID: begin
            if (sck_fall) begin
              miso <= tx[7];
              tx   <= {tx[6:0], 1'b0};
            end
            if (sck_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                tx      <= id_byte(JEDEC_ID, id_idx);
                if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          IGNORE: miso <= 1'b0;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: SPI master model, byte-addressed memory model, rd_en scoreboard.
module tb_spi_flash_responder;

  localparam int unsigned AW   = 24;
  localparam int unsigned HALF = 6;
  localparam int unsigned MIN_GAP = 16 * HALF - 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          cs;
  logic          mosi;
  logic          miso;
  logic          miso_oe;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic          active;
  logic          cmd_err;

  spi_flash_responder #(
    .ADDR_W      (AW),
    .JEDEC_ID    (24'hEF4016),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sclk    (sclk),
    .cs      (cs),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .active  (active),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_at(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hA5;
      24'h000011: return 8'h3C;
      24'h000004: return 8'h77;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem_at(rd_addr);

  int unsigned   checks = 0;
  int unsigned   passes = 0;
  int unsigned   err_seen = 0;
  longint        cyc = 0;
  longint        last_rd = -1;
  logic [23:0]   exp_rd_q[$];
  logic [23:0]   exp_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst && cmd_err) err_seen++;
    if (!rst && rd_en) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        $display("FAIL rd_en_unexpected: rd_addr=%0h, expected no read", rd_addr);
      end else begin
        exp_a = exp_rd_q.pop_front();
        chk("rd_addr", rd_addr, exp_a);
      end
      if (last_rd >= 0) chk("rd_en_spacing_ok", 32'((cyc - last_rd) >= MIN_GAP), 1);
      last_rd = cyc;
    end
  end

  task automatic xfer(input logic [7:0] out, input int unsigned nb, output logic [7:0] rx_byte);
    rx_byte = '0;
    for (int unsigned i = 0; i < nb; i++) begin
      mosi = out[7-i];
      repeat (HALF) @(negedge clk);
      rx_byte = {rx_byte[6:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("end_active", active, 0);
    chk("end_miso_oe", miso_oe, 0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int unsigned nbytes;
    logic [31:0] bytes_exp;
    int unsigned nerr;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input vec_t v);
    logic [7:0]  r;
    logic [23:0] a;
    logic [31:0] be;
    a  = v.addr;
    be = v.bytes_exp;
    if (v.op == 8'h03)
      for (int unsigned i = 0; i <= v.nbytes; i++) exp_rd_q.push_back(a + 24'(i));
    err_seen = 0;
    cs = 1'b0;
    xfer(v.op, 8, r);
    chk("cmd_phase_miso", r, 0);
    if (v.op == 8'h03) begin
      xfer(a[23:16], 8, r);
      xfer(a[15:8], 8, r);
      xfer(a[7:0], 8, r);
    end
    chk("frame_active", active, 1);
    chk("frame_miso_oe", miso_oe, 1);
    for (int unsigned i = 0; i < v.nbytes; i++) begin
      xfer(8'h00, 8, r);
      chk("data_byte", r, 32'(8'(be >> (24 - 8 * i))));
    end
    end_frame();
    chk("rd_outstanding", exp_rd_q.size(), 0);
    chk("cmd_err_count", err_seen, v.nerr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  r;
    int unsigned n;

    vecs[0] = '{op: 8'h03, addr: 24'h000010, nbytes: 2, bytes_exp: 32'hA53C0000, nerr: 0};
    vecs[1] = '{op: 8'h9F, addr: 24'h000000, nbytes: 4, bytes_exp: 32'hEF401600, nerr: 0};
    vecs[2] = '{op: 8'h55, addr: 24'h000000, nbytes: 2, bytes_exp: 32'h00000000, nerr: 1};
    vecs[3] = '{op: 8'h03, addr: 24'hFFFFFF, nbytes: 2,
                bytes_exp: {mem_at(24'hFFFFFF), mem_at(24'h000000), 16'h0000}, nerr: 0};
    vecs[4] = '{op: 8'h03, addr: 24'h000004, nbytes: 1, bytes_exp: 32'h77000000, nerr: 0};

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_active", active, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_rd_addr", rd_addr, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Abort after 12 address bits: no read may be issued.
    cs = 1'b0;
    xfer(8'h03, 8, r);
    xfer(8'h00, 8, r);
    xfer(8'h00, 4, r);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    n = 0;
    while (active && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort_active", active, 0);
    chk("abort_miso_oe", miso_oe, 0);
    repeat (10) @(negedge clk);
    run_frame(vecs[4]);

    // Reset in the middle of a JEDEC frame with cs still low.
    cs = 1'b0;
    xfer(8'h9F, 8, r);
    xfer(8'h00, 4, r);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_active", active, 0);
    xfer(8'h00, 8, r);
    chk("midrst_miso", r, 0);
    chk("midrst_still_idle", active, 0);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    chk("final_rd_outstanding", exp_rd_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI mode-0 slave that emulates a serial NOR flash on the other end of the flash SPI master's link.
- Decodes READ (0x03) with a 24-bit address and streams bytes from an attached memory read port, auto-incrementing the address.
- Decodes JEDEC ID (0x9F) and returns a fixed 3-byte ID.
- Used as an on-chip loopback target for the flash master and as the bench model in top-level simulation.

Parameters:
- ADDR_W, 10, width of memory read address; the low ADDR_W bits of the 24-bit SPI address are used.
- JEDEC_ID, 24'hEF4016, ID bytes returned MSB first for command 0x9F.
- SYNC_STAGES, 2, synchronizer depth on sclk/cs/mosi (min 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sclk  in  1  SPI clock from master, asynchronous to clk, idle low
- cs  in  1  chip select, active low
- mosi  in  1  master out
- miso  out  1  slave out, MSB first
- miso_oe  out  1  high while cs (synchronized) is low
- rd_en  out  1  one-cycle memory read strobe
- rd_addr  out  ADDR_W  memory read address
- rd_data  in  8  memory data, valid exactly 1 clk after rd_en
- active  out  1  high from cs-fall detect to cs-rise detect
- cmd_err  out  1  one-cycle pulse when an unsupported opcode completes

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0, FSM IDLE, shift/bit counters 0, address 0.
- Inputs: sclk, cs and mosi pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk.
- Sampling and output:
  - mosi is sampled on the synchronized sclk rising edge.
  - miso updates on the synchronized sclk falling edge.
- Timing requirement: the sclk high and low phases are each at least 4 clk. Behaviour below that is undefined.
- FSM:
  - IDLE: wait for cs fall; clear the bit counter; set active.
  - CMD: shift 8 bits.
    - 0x03 -> ADDR.
    - 0x9F -> ID: load shift register with JEDEC_ID[23:16]; miso drives bit 7 on the next falling edge.
    - Other -> pulse cmd_err, go to IGNORE.
  - ADDR: shift 24 bits. On the rising edge that captures bit 0, assert rd_en with rd_addr = addr[ADDR_W-1:0]. One clk later, load rd_data into the tx shift register. Then DATA.
  - DATA: each falling edge shifts out one bit, MSB first.
    - After the 8th rising edge of a byte, increment the address (24-bit wrap 0xFFFFFF -> 0x000000) and issue rd_en for the next byte.
    - The next byte loads before the following falling edge.
  - ID: output the 3 ID bytes, then 0x00 repeatedly.
  - IGNORE: miso held 0 until cs rises.
- Abort: cs rise in any state returns to IDLE within SYNC_STAGES+1 clk. Partial bits are discarded; active and miso_oe clear; no rd_en is issued after the cs rise is detected.
- Byte order: the first data bit on miso is bit 7 of mem[addr], driven on the falling edge following the 32nd rising edge.
- Edge cases:
  - sclk edges while cs is high are ignored.
  - If a cs fall and an sclk edge land in the same synchronized cycle, the cs fall is processed first and the edge still counts.
  - rst mid-transaction forces IDLE; the next transaction requires a fresh cs fall.
- rd_en is at most one pulse per byte, never back-to-back within 8 sclk periods.

Decomposition:
- Shared package spi_flash_pkg:
  - opcode constants CMD_READ=8'h03, CMD_JEDEC=8'h9F
  - FSM state enum (IDLE, CMD, ADDR, DATA, ID, IGNORE)
  - ADDR bit count constant 24
- One sub-module: spi_in_sync (parameterized N-stage synchronizer with rise/fall pulse outputs), instantiated for sclk, plus plain sync for cs and mosi.

Test Plan:
- rst high 3 clk -> miso, miso_oe, rd_en, active, cmd_err all 0; state IDLE.
- READ 0x03, addr 0x000010, memory holds 0xA5,0x3C at 0x10/0x11, 16 data clocks -> miso bytes 0xA5 then 0x3C; rd_addr 0x010 then 0x011, one rd_en each.
- JEDEC 0x9F, 40 clocks -> miso bytes 0xEF,0x40,0x16,0x00; no rd_en.
- Opcode 0x55 then 16 more clocks -> single cmd_err pulse after bit 8; miso 0 throughout; no rd_en.
- READ at 0xFFFFFF, 2 bytes with ADDR_W=24 -> rd_addr 0xFFFFFF then 0x000000.
- cs raised after 12 address bits, then new READ to 0x000004 (0x77) -> no rd_en in the aborted frame; second frame returns 0x77.
